// File: rtl/sp_mem_arb_pkg.sv
// Shared constants and round-robin pick helper for sp_mem_arbiter.
// Used by rr_arbiter and the sp_mem_arbiter top.
package sp_mem_arb_pkg;

  localparam int DefNumReq    = 4;
  localparam int DefDataWidth = 8;
  localparam int DefDataDepth = 4096;

  // Widest requester vector the pick helper handles.
  localparam int MaxReq = 32;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } pick_t;

  // First valid index at or after ptr, wrapping at n.
  function automatic pick_t rr_pick(
    input logic [MaxReq-1:0] valid,
    input int unsigned       n,
    input int unsigned       ptr
  );
    pick_t       p;
    int unsigned i;
    p = '0;
    for (int unsigned k = 0; k < MaxReq; k++) begin
      i = ptr + k;
      if (i >= n) i = i - n;
      if (k < n && !p.found && valid[i[4:0]]) begin
        p.found = 1'b1;
        p.idx   = i[4:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant from valid and ptr_q.
// ptr_q moves past the winner on every grant.
module rr_arbiter
  import sp_mem_arb_pkg::*;
#(
  parameter int NumReq   = DefNumReq,
  parameter int IdxWidth = (NumReq <= 1) ? 1 : $clog2(NumReq)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumReq-1:0]   valid_i,
  output logic [NumReq-1:0]   grant_o,
  output logic [IdxWidth-1:0] idx_o,
  output logic                found_o
);

  logic [IdxWidth-1:0] ptr_q, ptr_d;
  logic [MaxReq-1:0]   valid_ext;
  pick_t               pick;

  assign valid_ext = MaxReq'(valid_i);
  assign pick      = rr_pick(valid_ext, NumReq, 32'(ptr_q));
  assign idx_o     = pick.idx[IdxWidth-1:0];
  assign found_o   = pick.found;

  // One-hot grant for the picked requester.
  always_comb begin
    grant_o = '0;
    if (pick.found) grant_o[idx_o] = 1'b1;
  end

  // Next pointer: one past the winner, wrapping.
  always_comb begin
    ptr_d = ptr_q;
    if (pick.found) begin
      if (int'(idx_o) == NumReq - 1) ptr_d = '0;
      else ptr_d = idx_o + IdxWidth'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sp_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory.
// Define SP_MEM_ARB_WR_PRIO_EN to let writes pre-empt reads.
module sp_mem_arbiter
  import sp_mem_arb_pkg::*;
#(
  parameter int NumReq    = DefNumReq,
  parameter int DataWidth = DefDataWidth,
  parameter int DataDepth = DefDataDepth,
  parameter int AddrWidth = (DataDepth <= 1) ? 1 : $clog2(DataDepth),
  parameter int IdxWidth  = (NumReq <= 1) ? 1 : $clog2(NumReq)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumReq-1:0]                   req_valid_i,
  output logic [NumReq-1:0]                   req_ready_o,
  input  logic [NumReq-1:0][AddrWidth-1:0]    req_addr_i,
  input  logic [NumReq-1:0]                   req_we_i,
  input  logic [NumReq-1:0][DataWidth-1:0]    req_wr_data_i,
  output logic [NumReq-1:0]                   rsp_valid_o,
  output logic signed [DataWidth-1:0]         rsp_rd_data_o,
  output logic [AddrWidth-1:0]                mem_addr_o,
  output logic                                mem_we_o,
  output logic signed [DataWidth-1:0]         mem_wr_data_o,
  input  logic signed [DataWidth-1:0]         mem_rd_data_i
);

  logic [NumReq-1:0]   compete;
  logic [NumReq-1:0]   grant;
  logic [IdxWidth-1:0] win;
  logic                found;
  logic                rd_grant;

  logic [NumReq-1:0]          rsp_valid_q, rsp_valid_d;
  logic signed [DataWidth-1:0] rsp_data_q, rsp_data_d;

`ifdef SP_MEM_ARB_WR_PRIO_EN
  logic [NumReq-1:0] wr_req;
  assign wr_req  = req_valid_i & req_we_i;
  assign compete = (|wr_req) ? wr_req : req_valid_i;
`else
  assign compete = req_valid_i;
`endif

  rr_arbiter #(
    .NumReq   (NumReq),
    .IdxWidth (IdxWidth)
  ) u_rr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (compete),
    .grant_o (grant),
    .idx_o   (win),
    .found_o (found)
  );

  assign req_ready_o = grant;

  // Winner drives the memory port; idle port is all zero.
  always_comb begin
    mem_addr_o    = '0;
    mem_we_o      = 1'b0;
    mem_wr_data_o = '0;
    if (found) begin
      mem_addr_o    = req_addr_i[win];
      mem_we_o      = req_we_i[win];
      mem_wr_data_o = req_wr_data_i[win];
    end
  end

  assign rd_grant = found && !mem_we_o;

  // Read grants capture data; writes leave data untouched.
  always_comb begin
    rsp_valid_d = rd_grant ? grant : '0;
    rsp_data_d  = rd_grant ? mem_rd_data_i : rsp_data_q;
  end

  // Response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rd_data_o = rsp_data_q;

endmodule

// File: tb/tb_sp_mem_arbiter.sv
// Scoreboard bench for sp_mem_arbiter with a 16x8 memory model.
// Expected grants/responses are queued; a monitor compares.
module tb_sp_mem_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       vld, we, ready, rsp_v;
  logic [3:0][3:0]  addr;
  logic [3:0][7:0]  wd;
  logic [7:0]       rsp_d, mem_wd, mem_rd;
  logic [3:0]       mem_addr;
  logic             mem_we;

  int checks = 0;
  int errors = 0;

  logic [3:0] gq[$];
  logic [3:0] rvq[$];
  logic [7:0] rdq[$];

  always #5 clk = ~clk;

  sp_mem_arbiter #(
    .NumReq    (4),
    .DataWidth (8),
    .DataDepth (16)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_valid_i   (vld),
    .req_ready_o   (ready),
    .req_addr_i    (addr),
    .req_we_i      (we),
    .req_wr_data_i (wd),
    .rsp_valid_o   (rsp_v),
    .rsp_rd_data_o (rsp_d),
    .mem_addr_o    (mem_addr),
    .mem_we_o      (mem_we),
    .mem_wr_data_o (mem_wd),
    .mem_rd_data_i (mem_rd)
  );

  logic [7:0] mem [16];
  logic       filled = 1'b0;

  assign mem_rd = mem[mem_addr];

  always @(posedge clk) begin
    if (!filled) begin
      for (int k = 0; k < 16; k++) mem[k] <= 8'h10 + 8'(k);
      filled <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wd;
    end
  end

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (|ready) begin
      if (gq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL grant unexpected got %b expected none", ready);
      end else begin
        check("grant", 32'(ready), 32'(gq.pop_front()));
      end
    end
    if (|rsp_v) begin
      if (rvq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp unexpected got %b expected none", rsp_v);
      end else begin
        check("rsp_valid", 32'(rsp_v), 32'(rvq.pop_front()));
        check("rsp_data", 32'(rsp_d), 32'(rdq.pop_front()));
      end
    end
  end

  task automatic clr();
    vld = '0; we = '0; addr = '0; wd = '0;
  endtask

  task automatic rq(input int i, input logic w, input logic [3:0] a,
                    input logic [7:0] d);
    vld[i] = 1'b1; we[i] = w; addr[i] = a; wd[i] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic eg(input logic [3:0] g);
    gq.push_back(g);
  endtask

  task automatic er(input logic [3:0] v, input logic [7:0] d);
    rvq.push_back(v);
    rdq.push_back(d);
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    repeat (3) @(posedge clk);
    #1;
    check("reset rsp_valid", 32'(rsp_v), 32'h0);
    check("reset rsp_data", 32'(rsp_d), 32'h0);
    check("idle ready", 32'(ready), 32'h0);
    check("idle mem_we", 32'(mem_we), 32'h0);
    check("idle mem_addr", 32'(mem_addr), 32'h0);
    check("idle mem_wd", 32'(mem_wd), 32'h0);
    rst_n = 1'b1;
    step();

    // Write then read back same address.
    rq(0, 1'b1, 4'd3, 8'h5A); eg(4'b0001);
    step(); clr();
    rq(0, 1'b0, 4'd3, 8'h00); eg(4'b0001); er(4'b0001, 8'h5A);
    step(); clr();
    step();

    // Four held reads from reset: 0,1,2,3,0.
    rst_pulse();
    rq(0, 1'b0, 4'd8, 8'h0);
    rq(1, 1'b0, 4'd9, 8'h0);
    rq(2, 1'b0, 4'd10, 8'h0);
    rq(3, 1'b0, 4'd11, 8'h0);
    eg(4'b0001); er(4'b0001, 8'h18);
    eg(4'b0010); er(4'b0010, 8'h19);
    eg(4'b0100); er(4'b0100, 8'h1A);
    eg(4'b1000); er(4'b1000, 8'h1B);
    eg(4'b0001); er(4'b0001, 8'h18);
    repeat (5) step();
    clr();
    step();

    // ptr=1: grant req1 alone, ptr->2.
    rq(1, 1'b0, 4'd12, 8'h0); eg(4'b0010); er(4'b0010, 8'h1C);
    step(); clr();
    // req1,req2 with ptr=2: req2 first.
    rq(1, 1'b0, 4'd13, 8'h0);
    rq(2, 1'b0, 4'd14, 8'h0);
    eg(4'b0100); er(4'b0100, 8'h1E);
    step(); clr();
    rq(1, 1'b0, 4'd13, 8'h0); eg(4'b0010); er(4'b0010, 8'h1D);
    step(); clr();
    // ptr back at 2: req2 beats req0.
    rq(0, 1'b0, 4'd15, 8'h0);
    rq(2, 1'b0, 4'd15, 8'h0);
    eg(4'b0100); er(4'b0100, 8'h1F);
    step(); clr();
    rq(0, 1'b0, 4'd15, 8'h0); eg(4'b0001); er(4'b0001, 8'h1F);
    step(); clr();
    step();

    // Write -3 then read in next cycle.
    rq(0, 1'b1, 4'd5, 8'hFD); eg(4'b0001);
    step(); clr();
    rq(1, 1'b0, 4'd5, 8'h0); eg(4'b0010); er(4'b0010, 8'hFD);
    step(); clr();
    step();

    // Read vs write contention from ptr=0.
    rst_pulse();
    rq(0, 1'b0, 4'd8, 8'h0);
    rq(2, 1'b1, 4'd7, 8'h77);
`ifdef SP_MEM_ARB_WR_PRIO_EN
    eg(4'b0100);
    step(); clr();
    rq(0, 1'b0, 4'd8, 8'h0); eg(4'b0001); er(4'b0001, 8'h18);
    step();
`else
    eg(4'b0001); er(4'b0001, 8'h18);
    step(); clr();
    rq(2, 1'b1, 4'd7, 8'h77); eg(4'b0100);
    step();
`endif
    clr();
    step();

    // Reset right after a read grant drops the response.
    rq(0, 1'b0, 4'd9, 8'h0); eg(4'b0001);
    step(); clr();
    rst_n = 1'b0;
    #1;
    check("midreset rsp_valid", 32'(rsp_v), 32'h0);
    check("midreset rsp_data", 32'(rsp_d), 32'h0);
    step();
    rst_n = 1'b1;
    rq(0, 1'b0, 4'd5, 8'h0);
    rq(3, 1'b0, 4'd7, 8'h0);
    eg(4'b0001); er(4'b0001, 8'hFD);
    step(); clr();
    rq(3, 1'b0, 4'd7, 8'h0); eg(4'b1000); er(4'b1000, 8'h77);
    step(); clr();
    step();
    step();

    check("grants pending", 32'(gq.size()), 32'h0);
    check("rsps pending", 32'(rvq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
